// File: rtl/painel_pkg.sv
// painel_pkg: shared state encoding, BCD width and active-low 7-segment patterns
// (bit 0 = segment a ... bit 6 = segment g) for the panel countdown timer.
`default_nettype none

package painel_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] clamp_nibble(input logic [BCD_W-1:0] d,
                                                    input logic [BCD_W-1:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/painel_temporizador_bcd_sincroniza_borda.sv
// sincroniza_borda: 2-flop synchronizer for an asynchronous divided clock plus
// a rising-edge detector producing a one-cycle pulse in the clk domain.
`default_nettype none

module sincroniza_borda
  import painel_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  // [0],[1] = synchronizer stages, [2] = previous synchronized level
  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], async_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= 3'b000;
    else        sh_q <= sh_d;
  end

  assign pulse = sh_q[1] & ~sh_q[2];

endmodule

`default_nettype wire

// File: rtl/painel_temporizador_bcd.sv
// painel_temporizador_bcd: MM:SS BCD countdown with start/pause/load and a 4-digit
// multiplexed 7-segment driver. Optional macro BLINK_DONE_EN blinks the display in DONE.
`default_nettype none

module painel_temporizador_bcd
  import painel_pkg::*;
#(
  parameter logic [7:0] INIT_MIN = 8'h10,
  parameter logic [7:0] INIT_SEC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_cont_in,
  input  logic       clk_scan_in,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       running,
  output logic       expired
);

  logic tick_cont, tick_scan;

  sincroniza_borda u_sync_cont (.clk(clk), .rst_n(rst_n), .async_in(clk_cont_in), .pulse(tick_cont));
  sincroniza_borda u_sync_scan (.clk(clk), .rst_n(rst_n), .async_in(clk_scan_in), .pulse(tick_scan));

  state_t     state_q, state_d;
  logic [7:0] min_q, min_d, sec_q, sec_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       blink_on;

  logic [7:0]       dec_min, dec_sec, ld_min, ld_sec;
  logic [BCD_W-1:0] scan_digit;
  logic             count_zero, dec_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_q   <= INIT_MIN;
      sec_q   <= INIT_SEC;
      idx_q   <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  // One-second BCD borrow chain; only used while the count is non-zero.
  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q[3:0] != 4'd0) begin
      dec_sec[3:0] = sec_q[3:0] - 4'd1;
    end else begin
      dec_sec[3:0] = 4'd9;
      if (sec_q[7:4] != 4'd0) begin
        dec_sec[7:4] = sec_q[7:4] - 4'd1;
      end else begin
        dec_sec[7:4] = 4'd5;
        if (min_q[3:0] != 4'd0) begin
          dec_min[3:0] = min_q[3:0] - 4'd1;
        end else begin
          dec_min[3:0] = 4'd9;
          dec_min[7:4] = min_q[7:4] - 4'd1;
        end
      end
    end
    ld_min     = {clamp_nibble(load_min[7:4], 4'd9), clamp_nibble(load_min[3:0], 4'd9)};
    ld_sec     = {clamp_nibble(load_sec[7:4], 4'd5), clamp_nibble(load_sec[3:0], 4'd9)};
    count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    dec_zero   = (dec_min == 8'h00) && (dec_sec == 8'h00);
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (btn_load) begin
      state_d = IDLE;
      min_d   = ld_min;
      sec_d   = ld_sec;
    end else begin
      case (state_q)
        IDLE, PAUSE: if (btn_start && !count_zero) state_d = RUN;
        RUN: begin
          if (btn_pause) begin
            state_d = PAUSE;
          end else if (tick_cont) begin
            min_d = dec_min;
            sec_d = dec_sec;
            if (dec_zero) state_d = DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Scan shows the digit selected by the new index, taken from the current count.
  always_comb begin
    idx_d = tick_scan ? idx_q + 2'd1 : idx_q;
    case (idx_d)
      2'd0:    scan_digit = sec_q[3:0];
      2'd1:    scan_digit = sec_q[7:4];
      2'd2:    scan_digit = min_q[3:0];
      default: scan_digit = min_q[7:4];
    endcase
    an_d  = tick_scan ? ~(4'b0001 << idx_d) : an_q;
    seg_d = tick_scan ? seg_decode(scan_digit) : seg_q;
    dp_d  = tick_scan ? (idx_d != 2'd2) : dp_q;
  end

`ifdef BLINK_DONE_EN
  logic blink_q, blink_d;

  always_comb begin
    if (state_d != DONE)                   blink_d = 1'b0;
    else if (state_q == DONE && tick_cont) blink_d = ~blink_q;
    else                                   blink_d = blink_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end

  assign blink_on = blink_q;
`else
  assign blink_on = 1'b0;
`endif

  always_comb begin
    running = (state_q == RUN);
    expired = (state_q == DONE);
    an      = an_q;
    seg     = blink_on ? SEG_BLANK : seg_q;
    dp      = blink_on ? 1'b1 : dp_q;
  end

endmodule

`default_nettype wire

// File: doc/painel_temporizador_bcd.md
Name: painel_temporizador_bcd

Overview:
- Countdown timer stage directly downstream of the panel frequency divider.
- Consumes the divider's two divided clocks (1 Hz count clock, display-scan clock) as asynchronous levels and converts them to single-cycle enables in the `clk` domain.
- Counts MM:SS down in BCD under start/pause/load control.
- Drives a 4-digit multiplexed 7-segment display.

Parameters:
- INIT_MIN, 8'h10, BCD minutes loaded at reset.
- INIT_SEC, 8'h00, BCD seconds loaded at reset; tens digit must be ≤5.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clk_cont_in  input  1  divided count clock from the divider; asynchronous to clk; rising edge = 1 s.
- clk_scan_in  input  1  divided scan clock from the divider; asynchronous to clk; rising edge = advance digit.
- btn_start  input  1  one-cycle start/resume request.
- btn_pause  input  1  one-cycle pause request.
- btn_load  input  1  one-cycle load request.
- load_min  input  8  BCD minutes for load.
- load_sec  input  8  BCD seconds for load.
- seg  output  7  segments a..g, active-low.
- an  output  4  digit enables, active-low one-hot.
- dp  output  1  decimal point, active-low; lit only on digit 2 (the colon position).
- running  output  1  high in RUN.
- expired  output  1  high in DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, count=INIT_MIN:INIT_SEC, digit index=0.
  - an=4'b1110, seg=7'h7F (blank), dp=1.
  - running=0, expired=0.
  - Synchronizer and edge-detect flops clear to 0.
- Tick generation:
  - Each divided clock passes through a 2-flop synchronizer plus a rising-edge detector.
  - Result is a one-cycle tick; the first count/scan update is visible on the 3rd clk edge after the input rises.
  - A falling edge produces no tick.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Request priority when several are asserted in one cycle: load > pause > start.
  - load: any state → IDLE, count=load value.
  - pause: RUN → PAUSE; ignored in other states.
  - start: IDLE/PAUSE → RUN, only if count≠00:00. In DONE, start is ignored until a load.
- A count tick is honoured only in RUN and only if no load/pause request is present in the same cycle.
- Decrement (BCD, per tick in RUN):
  - sec units 0 → 9 with borrow.
  - sec tens 0 → 5 with borrow.
  - Borrow into minutes: minute units 0 → 9, minute tens decrement.
  - When count goes 00:01 → 00:00: state → DONE in the same cycle, running=0, expired=1.
- Load sanitising:
  - any BCD nibble >9 → 9.
  - seconds tens >5 → 5.
  - load of 00:00 → IDLE; start is then ignored.
- Scan (each scan tick, in every state, including IDLE/PAUSE/DONE):
  - digit index increments mod 4: 0=sec units, 1=sec tens, 2=min units, 3=min tens.
  - an and seg are registered together: seg = decoded digit of the current count, an = one-hot low of the new index.
  - No leading-zero blanking.
- Reset mid-RUN aborts immediately; no tick or request is remembered.

Optional Feature:
- Macro: BLINK_DONE_EN.
- Defined: in DONE, an internal blink flag toggles on each count tick; while it is 1, seg=7'h7F and dp=1 (scan continues). The flag clears on leaving DONE and on reset.
- Undefined: DONE shows a steady 00:00; count ticks in DONE have no effect.

Decomposition:
- Package painel_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - Seven-segment active-low pattern constants for 0–9 and blank.
  - BCD nibble width constant.
- Sub-module sincroniza_borda: 2-flop synchronizer plus rising-edge pulse. Instantiated twice, once for clk_cont_in and once for clk_scan_in.

Test Plan:
- Reset with defaults, then start; apply 3 clk_cont_in rising edges → count 09:57, running=1, each update 3 clk after the edge.
- load 00:02, start, 2 ticks → 00:00, state DONE, expired=1, running=0; a further start → no change.
- Count 01:00 in RUN, 1 tick → 00:59; pause and a tick in the same cycle → PAUSE, count stays 00:59; 5 ticks in PAUSE → unchanged; start → RUN.
- load_min=8'h1C, load_sec=8'h7A → count 19:59 in IDLE.
- Apply 4 scan edges with count 12:34 → an sequence 1101, 1011, 0111, 1110 with seg digits 3, 2, 1, 4; dp=0 only when an=1011.
- Assert rst_n low mid-RUN at 05:17 → async return to the reset values; with BLINK_DONE_EN defined, DONE blanks seg on alternate ticks.
